// File: rtl/digest_serializer.sv
// Double-buffered digest serializer: collects WORD_COUNT core words into a fill
// buffer, swaps them into a drain buffer and streams them as OUT_WIDTH-bit
// symbols, paced by the UART TX_active_in / TX_done_in handshake.
module digest_serializer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned WORD_COUNT = 8,
  parameter int unsigned OUT_WIDTH  = 8,
  parameter int unsigned MSB_FIRST  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] core_byte_in,
  input  logic                  RX_DV_in,
  output logic                  core_ready_out,
  input  logic                  TX_active_in,
  input  logic                  TX_done_in,
  output logic [OUT_WIDTH-1:0]  MP_data_out,
  output logic                  MP_dv_out,
  output logic                  busy_out,
  output logic                  overflow_err_out
);

  localparam int unsigned SPW = DATA_WIDTH / OUT_WIDTH;
  localparam int unsigned SYM = WORD_COUNT * SPW;
  localparam int unsigned SCW = $clog2(SYM + 1);
  localparam int unsigned FCW = $clog2(WORD_COUNT + 1);
  localparam int unsigned WIW = (WORD_COUNT > 1) ? $clog2(WORD_COUNT) : 1;
  localparam int unsigned SIW = (SPW > 1) ? $clog2(SPW) : 1;

  typedef enum logic [1:0] {StIdle, StPresent, StWaitDone} state_e;

  logic [DATA_WIDTH-1:0] r_fill  [WORD_COUNT];
  logic [DATA_WIDTH-1:0] r_drain [WORD_COUNT];
  logic [FCW-1:0]        r_fill_cnt;
  logic                  r_fill_full;
  logic                  r_ready;
  logic                  r_overflow;
  state_e                r_state;
  logic [SCW-1:0]        r_sym_cnt;
  logic [WIW-1:0]        r_word_idx;
  logic [SIW-1:0]        r_sym_idx;
  logic [OUT_WIDTH-1:0]  r_data;
  logic                  r_dv;
  logic                  r_busy;

  logic                  w_accept;
  logic                  w_swap;
  logic                  w_last_word;
  logic [DATA_WIDTH-1:0] w_word;
  logic [OUT_WIDTH-1:0]  w_sym;

  // r_ready mirrors !r_fill_full, so a swap and a capture can never coincide.
  assign w_accept    = RX_DV_in && r_ready;
  assign w_swap      = r_fill_full && (r_state == StIdle);
  assign w_last_word = (r_fill_cnt == FCW'(WORD_COUNT - 1));

  // Fill-side control: word counter, full flag, ready and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fill_cnt  <= '0;
      r_fill_full <= 1'b0;
      r_ready     <= 1'b1;
      r_overflow  <= 1'b0;
    end else begin
      if (RX_DV_in && !r_ready) begin
        r_overflow <= 1'b1;
      end
      if (w_swap) begin
        r_fill_cnt  <= '0;
        r_fill_full <= 1'b0;
        r_ready     <= 1'b1;
      end else if (w_accept) begin
        r_fill_cnt <= r_fill_cnt + FCW'(1);
        if (w_last_word) begin
          r_fill_full <= 1'b1;
          r_ready     <= 1'b0;
        end
      end
    end
  end

  // Fill buffer storage: accepted word lands in slot r_fill_cnt.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      for (int unsigned i = 0; i < WORD_COUNT; i++) begin
        if (r_fill_cnt == FCW'(i)) begin
          r_fill[i] <= core_byte_in;
        end
      end
    end
  end

  // Drain buffer storage: whole digest copied across on a swap.
  always_ff @(posedge clk) begin
    if (w_swap) begin
      r_drain <= r_fill;
    end
  end

  // Select the current symbol from the drain buffer.
  always_comb begin
    w_word = '0;
    for (int unsigned i = 0; i < WORD_COUNT; i++) begin
      if (r_word_idx == WIW'(i)) begin
        w_word = r_drain[i];
      end
    end
    w_sym = '0;
    for (int unsigned k = 0; k < SPW; k++) begin
      if (r_sym_idx == SIW'(k)) begin
        if (MSB_FIRST != 0) begin
          w_sym = w_word[(SPW-1-k)*OUT_WIDTH +: OUT_WIDTH];
        end else begin
          w_sym = w_word[k*OUT_WIDTH +: OUT_WIDTH];
        end
      end
    end
  end

  // Drain FSM: present a symbol, wait for the UART to finish it, repeat.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= StIdle;
      r_sym_cnt  <= '0;
      r_word_idx <= '0;
      r_sym_idx  <= '0;
      r_data     <= '0;
      r_dv       <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_dv <= 1'b0;
      case (r_state)
        StIdle: begin
          if (w_swap) begin
            r_sym_cnt  <= '0;
            r_word_idx <= '0;
            r_sym_idx  <= '0;
            r_busy     <= 1'b1;
            r_state    <= StPresent;
          end
        end
        StPresent: begin
          if (!TX_active_in) begin
            r_data  <= w_sym;
            r_dv    <= 1'b1;
            r_state <= StWaitDone;
          end
        end
        StWaitDone: begin
          if (TX_done_in) begin
            r_sym_cnt <= r_sym_cnt + SCW'(1);
            if (r_sym_idx == SIW'(SPW - 1)) begin
              r_sym_idx  <= '0;
              r_word_idx <= r_word_idx + WIW'(1);
            end else begin
              r_sym_idx <= r_sym_idx + SIW'(1);
            end
            if (r_sym_cnt == SCW'(SYM - 1)) begin
              r_state <= StIdle;
              r_busy  <= 1'b0;
            end else begin
              r_state <= StPresent;
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign core_ready_out   = r_ready;
  assign MP_data_out      = r_data;
  assign MP_dv_out        = r_dv;
  assign busy_out         = r_busy;
  assign overflow_err_out = r_overflow;

endmodule

// File: tb/tb_digest_serializer.sv
// Bench for digest_serializer: three configurations (default, LSB-first,
// WORD_COUNT=7) share one stimulus path selected by 'sel'.
module tb_digest_serializer;

  localparam logic [255:0] Sha256 =
    256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] Sha224 =
    256'h23097d22_3405d822_8642a477_bda255b3_2aadbce4_bda0b3f7_e36c9da7_00000000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] d_byte;
  logic        d_dv, d_active, d_done;
  int          sel;

  logic [2:0] ready, dv, busy, ovf;
  logic [7:0] data [3];
  logic       m_ready, m_dv, m_busy, m_ovf;
  logic [7:0] m_data;

  digest_serializer u_dut0 (
    .clk(clk), .rst(rst), .core_byte_in(d_byte), .RX_DV_in(d_dv && sel == 0),
    .core_ready_out(ready[0]), .TX_active_in(d_active && sel == 0),
    .TX_done_in(d_done && sel == 0), .MP_data_out(data[0]), .MP_dv_out(dv[0]),
    .busy_out(busy[0]), .overflow_err_out(ovf[0])
  );

  digest_serializer #(.MSB_FIRST(0)) u_dut1 (
    .clk(clk), .rst(rst), .core_byte_in(d_byte), .RX_DV_in(d_dv && sel == 1),
    .core_ready_out(ready[1]), .TX_active_in(d_active && sel == 1),
    .TX_done_in(d_done && sel == 1), .MP_data_out(data[1]), .MP_dv_out(dv[1]),
    .busy_out(busy[1]), .overflow_err_out(ovf[1])
  );

  digest_serializer #(.WORD_COUNT(7)) u_dut2 (
    .clk(clk), .rst(rst), .core_byte_in(d_byte), .RX_DV_in(d_dv && sel == 2),
    .core_ready_out(ready[2]), .TX_active_in(d_active && sel == 2),
    .TX_done_in(d_done && sel == 2), .MP_data_out(data[2]), .MP_dv_out(dv[2]),
    .busy_out(busy[2]), .overflow_err_out(ovf[2])
  );

  assign m_ready = ready[sel];
  assign m_dv    = dv[sel];
  assign m_busy  = busy[sel];
  assign m_ovf   = ovf[sel];
  assign m_data  = data[sel];

  typedef struct {
    int           sel;
    logic [255:0] words;
    int           nw;
    int           gap;
    logic [31:0]  first4;
    logic [7:0]   last;
    int           count;
  } vec_t;

  vec_t       vecs [3];
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] exp_q [$];
  logic [7:0] seen  [$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference symbol order for one word in the selected configuration.
  task automatic push_syms(input logic [31:0] w);
    for (int k = 0; k < 4; k++) begin
      if (sel != 1) exp_q.push_back(w[31-8*k -: 8]);
      else          exp_q.push_back(w[8*k +: 8]);
    end
  endtask

  task automatic load_word(input logic [31:0] w);
    d_byte = w;
    d_dv   = 1'b1;
    tick();
    d_dv   = 1'b0;
  endtask

  task automatic load_digest(input logic [255:0] words, input int nw);
    logic [31:0] w;
    for (int i = 0; i < nw; i++) begin
      w = words[255-32*i -: 32];
      check("ready_before_word", {31'b0, m_ready}, 32'd1);
      load_word(w);
      push_syms(w);
    end
  endtask

  // UART model: acks nsym symbols, holding busy for 'gap' cycles on each.
  task automatic drain(input int nsym, input int gap);
    int         got = 0;
    int         cyc = 0;
    logic [7:0] held;
    while (got < nsym) begin
      if (m_dv) begin
        held = m_data;
        seen.push_back(held);
        if (exp_q.size() == 0) check("unexpected_symbol", {24'b0, held}, 32'hffffffff);
        else                   check("symbol", {24'b0, held}, {24'b0, exp_q.pop_front()});
        d_active = 1'b1;
        repeat (gap) begin
          tick();
          check("dv_one_cycle", {31'b0, m_dv}, 32'd0);
          check("data_held", {24'b0, m_data}, {24'b0, held});
        end
        d_active = 1'b0;
        d_done   = 1'b1;
        tick();
        d_done   = 1'b0;
        got++;
        cyc = 0;
      end else begin
        tick();
        cyc++;
        if (cyc > 60) begin
          n_tests++;
          n_fail++;
          $display("FAIL drain_timeout: got %0d of %0d symbols", got, nsym);
          return;
        end
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, {31'b0, m_ready}, 32'd1);
    check({tag, "_data"},  {24'b0, m_data},  32'd0);
    check({tag, "_dv"},    {31'b0, m_dv},    32'd0);
    check({tag, "_busy"},  {31'b0, m_busy},  32'd0);
    check({tag, "_ovf"},   {31'b0, m_ovf},   32'd0);
  endtask

  initial begin
    int extra;
    rst = 1'b1; d_byte = '0; d_dv = 1'b0; d_active = 1'b0; d_done = 1'b0; sel = 0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      check_reset_outputs("reset");
    end

    vecs[0] = '{sel: 0, words: Sha256, nw: 8, gap: 0, first4: 32'hba7816bf,
                last: 8'had, count: 32};
    vecs[1] = '{sel: 1, words: Sha256, nw: 8, gap: 2, first4: 32'hbf1678ba,
                last: 8'hf2, count: 32};
    vecs[2] = '{sel: 2, words: Sha224, nw: 7, gap: 1, first4: 32'h23097d22,
                last: 8'ha7, count: 28};

    for (int v = 0; v < 3; v++) begin
      sel = vecs[v].sel;
      exp_q.delete();
      seen.delete();
      load_digest(vecs[v].words, vecs[v].nw);
      drain(vecs[v].count, vecs[v].gap);
      check("busy_after_digest", {31'b0, m_busy}, 32'd0);
      check("symbol_count", seen.size(), vecs[v].count);
      check("first_four", {seen[0], seen[1], seen[2], seen[3]}, vecs[v].first4);
      check("last_symbol", {24'b0, seen[seen.size()-1]}, {24'b0, vecs[v].last});
      extra = 0;
      repeat (30) begin
        tick();
        if (m_dv) extra++;
      end
      check("no_extra_dv", extra, 0);
      check("queue_empty", exp_q.size(), 0);
    end

    // Second digest loaded while the first is stalled on TX_active_in.
    sel = 0;
    exp_q.delete();
    seen.delete();
    d_active = 1'b1;
    load_digest(Sha256, 8);
    tick();
    check("b2b_busy_stalled", {31'b0, m_busy}, 32'd1);
    load_digest({Sha224[255:32], 32'h0badf00d}, 8);
    check("b2b_stall_no_dv", {31'b0, m_dv}, 32'd0);
    check("b2b_ready_low", {31'b0, m_ready}, 32'd0);
    d_active = 1'b0;
    drain(32, 0);
    check("b2b_idle_dv", {31'b0, m_dv}, 32'd0);
    check("b2b_idle_busy", {31'b0, m_busy}, 32'd0);
    tick();
    check("b2b_swap_dv", {31'b0, m_dv}, 32'd0);
    check("b2b_swap_ready", {31'b0, m_ready}, 32'd1);
    check("b2b_swap_busy", {31'b0, m_busy}, 32'd1);
    tick();
    check("b2b_first_dv", {31'b0, m_dv}, 32'd1);
    drain(32, 1);
    check("b2b_ovf", {31'b0, m_ovf}, 32'd0);
    check("b2b_count", seen.size(), 64);
    check("b2b_queue_empty", exp_q.size(), 0);

    // Both buffers full plus one extra word on the LSB-first instance.
    sel = 1;
    exp_q.delete();
    seen.delete();
    d_active = 1'b1;
    load_digest(Sha256, 8);
    tick();
    load_digest({Sha224[255:32], 32'hdeadbeef}, 8);
    check("ovf_ready_low", {31'b0, m_ready}, 32'd0);
    check("ovf_clear_before", {31'b0, m_ovf}, 32'd0);
    load_word(32'h55555555);
    check("ovf_set", {31'b0, m_ovf}, 32'd1);
    repeat (3) tick();
    d_active = 1'b0;
    drain(32, 1);
    drain(32, 0);
    check("ovf_sticky", {31'b0, m_ovf}, 32'd1);
    check("ovf_count", seen.size(), 64);
    check("ovf_queue_empty", exp_q.size(), 0);

    // Reset in the middle of a digest, then a fresh digest from symbol 0.
    sel = 0;
    exp_q.delete();
    seen.delete();
    load_digest(Sha256, 8);
    drain(10, 1);
    rst = 1'b1;
    tick();
    check_reset_outputs("midrst");
    rst = 1'b0;
    exp_q.delete();
    seen.delete();
    load_digest({Sha224[255:32], 32'h0123abcd}, 8);
    drain(32, 0);
    check("restart_first_sym", {24'b0, seen[0]}, 32'h23);
    check("restart_busy", {31'b0, m_busy}, 32'd0);
    check("restart_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
